// File: rtl/ecc_mem_pkg.sv
// Shared SECDED definitions: code geometry helpers, the encoder and the
// status / scrub-state enumerations used by the controller and decoder.
package ecc_mem_pkg;

    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_CODE_WIDTH = 72;

    typedef enum logic [1:0] {ECC_OK, ECC_SBE, ECC_DBE} ecc_status_t;
    typedef enum logic {SCRUB_IDLE, SCRUB_PEND} scrub_state_t;

    // Hamming check bits plus one overall parity bit.
    function automatic int ecc_width(input int data_width);
        int r;
        r = 1;
        for (int k = 15; k >= 1; k--) begin
            if ((1 << k) >= data_width + k + 1) begin
                r = k;
            end
        end
        return r + 1;
    endfunction

    function automatic int code_width(input int data_width);
        return data_width + ecc_width(data_width);
    endfunction

    // Codeword index of data bit k: the k-th index that is not a power of two.
    function automatic int data_pos(input int k);
        int n;
        int pos;
        n = 0;
        pos = 0;
        for (int i = 1; i < MAX_CODE_WIDTH; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == k) begin
                    pos = i;
                end
                n++;
            end
        end
        return pos;
    endfunction

    function automatic logic [MAX_CODE_WIDTH-1:0] secded_encode(
        input logic [MAX_DATA_WIDTH-1:0] data,
        input int data_width
    );
        logic [MAX_CODE_WIDTH-1:0] code;
        logic par;
        int cw;
        int pos;
        cw = code_width(data_width);
        code = '0;
        for (int k = 0; k < MAX_DATA_WIDTH; k++) begin
            if (k < data_width) begin
                pos = data_pos(k);
                code[pos[6:0]] = data[k];
            end
        end
        for (int j = 0; j < 7; j++) begin
            pos = 1 << j;
            if (pos < cw) begin
                par = 1'b0;
                for (int i = 1; i < MAX_CODE_WIDTH; i++) begin
                    if (i < cw && (i & pos) != 0) begin
                        par = par ^ code[i[6:0]];
                    end
                end
                code[pos[6:0]] = par;
            end
        end
        code[0] = ^code;
        return code;
    endfunction

endpackage

// File: rtl/ecc_mem_ctrl_secded_decoder.sv
// Combinational SECDED decoder: syndrome, overall parity, single-bit
// correction and data extraction from the Hamming-position codeword.
module secded_decoder
    import ecc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int CODE_WIDTH = code_width(DATA_WIDTH),
    localparam int SYN_WIDTH = $clog2(CODE_WIDTH)
) (
    input  logic [CODE_WIDTH-1:0] codeword,
    output logic [DATA_WIDTH-1:0] data,
    output ecc_status_t           status,
    output logic [SYN_WIDTH-1:0]  syndrome
);

    logic                  parity;
    logic [CODE_WIDTH-1:0] fixed;

    always_comb begin
        syndrome = '0;
        for (int i = 1; i < CODE_WIDTH; i++) begin
            if (codeword[i]) begin
                syndrome = syndrome ^ SYN_WIDTH'(i);
            end
        end
    end

    assign parity = ^codeword;

    // A syndrome pointing past the codeword cannot be a single flip.
    always_comb begin
        status = ECC_OK;
        fixed  = codeword;
        if (parity) begin
            if (int'(syndrome) < CODE_WIDTH) begin
                status = ECC_SBE;
                fixed  = codeword ^ (CODE_WIDTH'(1) << syndrome);
            end else begin
                status = ECC_DBE;
            end
        end else if (syndrome != '0) begin
            status = ECC_DBE;
        end
    end

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_extract
        localparam int POS = data_pos(gi);
        assign data[gi] = fixed[POS];
    end

endmodule

// File: rtl/ecc_mem_ctrl.sv
// SECDED memory controller: encodes writes, decodes/corrects reads, scrubs
// single-bit errors back to memory and keeps saturating error statistics.
module ecc_mem_ctrl
    import ecc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_CTRL_ADDR_WIDTH = 10,
    parameter int CNT_WIDTH = 8,
    localparam int CODE_WIDTH = code_width(DATA_WIDTH),
    localparam int AW = MEM_CTRL_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  hw_rst,
    input  logic                  ECC_ctrl_wr_en,
    input  logic [AW:0]           ECC_ctrl_wr_addr_bus,
    input  logic [DATA_WIDTH-1:0] ECC_ctrl_write_data_bus,
    input  logic                  ECC_ctrl_rd_en,
    input  logic [AW:0]           ECC_ctrl_rd_addr_bus,
    output logic [DATA_WIDTH-1:0] ECC_ctrl_data_out,
    output logic                  ECC_ctrl_rd_valid,
    input  logic                  inj_sbe,
    input  logic                  inj_dbe,
    input  logic                  err_clr,
    output logic                  sbe_flag,
    output logic                  dbe_flag,
    output logic                  sbe_sticky,
    output logic                  dbe_sticky,
    output logic [CNT_WIDTH-1:0]  sbe_count,
    output logic [CNT_WIDTH-1:0]  dbe_count,
    output logic [AW-1:0]         err_addr,
    output logic                  scrub_busy,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_waddr,
    output logic [CODE_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic [AW-1:0]         mem_raddr,
    input  logic [CODE_WIDTH-1:0] mem_rdata
);

    localparam int SYN_WIDTH = $clog2(CODE_WIDTH);

    logic [AW-1:0]             wr_addr;
    logic [AW-1:0]             rd_addr;
    logic [MAX_CODE_WIDTH-1:0] wr_full;
    logic [MAX_CODE_WIDTH-1:0] scrub_full;
    logic [CODE_WIDTH-1:0]     inj_mask;
    logic [DATA_WIDTH-1:0]     dec_data;
    ecc_status_t               dec_status;
    logic [SYN_WIDTH-1:0]      dec_syndrome;
    logic                      pack_unused;

    logic                      rd_pend_reg;
    logic [AW-1:0]             rd_addr_reg;
    logic                      rd_hazard_reg;
    scrub_state_t              state_reg, state_next;
    logic [AW-1:0]             scrub_addr_reg;
    logic [CODE_WIDTH-1:0]     scrub_code_reg;
    logic                      scrub_we;
    logic                      scrub_block;

    assign wr_addr = ECC_ctrl_wr_addr_bus[AW-1:0];
    assign rd_addr = ECC_ctrl_rd_addr_bus[AW-1:0];

    assign wr_full    = secded_encode(MAX_DATA_WIDTH'(ECC_ctrl_write_data_bus), DATA_WIDTH);
    assign scrub_full = secded_encode(MAX_DATA_WIDTH'(dec_data), DATA_WIDTH);
    assign inj_mask   = (CODE_WIDTH'(inj_sbe | inj_dbe) << 3) | (CODE_WIDTH'(inj_dbe) << 5);

    // Wrap bits, encoder headroom and the syndrome are not needed here.
    assign pack_unused = ECC_ctrl_wr_addr_bus[AW] ^ ECC_ctrl_rd_addr_bus[AW]
                       ^ (^wr_full[MAX_CODE_WIDTH-1:CODE_WIDTH])
                       ^ (^scrub_full[MAX_CODE_WIDTH-1:CODE_WIDTH])
                       ^ (^dec_syndrome);

    secded_decoder #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_dec (
        .codeword(mem_rdata),
        .data    (dec_data),
        .status  (dec_status),
        .syndrome(dec_syndrome)
    );

    // Functional writes always own the port; the scrub only fills idle cycles.
    assign mem_we    = !hw_rst && (ECC_ctrl_wr_en || scrub_we);
    assign mem_waddr = ECC_ctrl_wr_en ? wr_addr : scrub_addr_reg;
    assign mem_wdata = ECC_ctrl_wr_en ? (wr_full[CODE_WIDTH-1:0] ^ inj_mask) : scrub_code_reg;
    assign mem_re    = !hw_rst && ECC_ctrl_rd_en;
    assign mem_raddr = rd_addr;

    assign ECC_ctrl_rd_valid = rd_pend_reg;
    assign ECC_ctrl_data_out = dec_data;
    assign sbe_flag          = rd_pend_reg && (dec_status == ECC_SBE);
    assign dbe_flag          = rd_pend_reg && (dec_status == ECC_DBE);
    assign scrub_busy        = (state_reg == SCRUB_PEND);

    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            rd_pend_reg   <= 1'b0;
            rd_addr_reg   <= '0;
            rd_hazard_reg <= 1'b0;
        end else begin
            rd_pend_reg   <= ECC_ctrl_rd_en;
            rd_addr_reg   <= rd_addr;
            rd_hazard_reg <= ECC_ctrl_rd_en && ECC_ctrl_wr_en && (wr_addr == rd_addr);
        end
    end

    // A write to the same word while the read is in flight makes the
    // corrected value stale, so such a read is not scrubbed.
    assign scrub_block = rd_hazard_reg || (ECC_ctrl_wr_en && (wr_addr == rd_addr_reg));

    always_comb begin
        state_next = state_reg;
        scrub_we   = 1'b0;
        case (state_reg)
            SCRUB_IDLE: begin
                if (sbe_flag && !scrub_block) begin
                    state_next = SCRUB_PEND;
                end
            end
            SCRUB_PEND: begin
                if (!ECC_ctrl_wr_en) begin
                    scrub_we   = 1'b1;
                    state_next = SCRUB_IDLE;
                end else if (wr_addr == scrub_addr_reg) begin
                    state_next = SCRUB_IDLE;
                end
            end
            default: state_next = SCRUB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            state_reg      <= SCRUB_IDLE;
            scrub_addr_reg <= '0;
            scrub_code_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == SCRUB_IDLE && state_next == SCRUB_PEND) begin
                scrub_addr_reg <= rd_addr_reg;
                scrub_code_reg <= scrub_full[CODE_WIDTH-1:0];
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            sbe_count  <= '0;
            dbe_count  <= '0;
            sbe_sticky <= 1'b0;
            dbe_sticky <= 1'b0;
            err_addr   <= '0;
        end else if (err_clr) begin
            sbe_count  <= '0;
            dbe_count  <= '0;
            sbe_sticky <= 1'b0;
            dbe_sticky <= 1'b0;
            err_addr   <= '0;
        end else if (dbe_flag) begin
            if (dbe_count != '1) begin
                dbe_count <= dbe_count + 1'b1;
            end
            dbe_sticky <= 1'b1;
            err_addr   <= rd_addr_reg;
        end else if (sbe_flag) begin
            if (sbe_count != '1) begin
                sbe_count <= sbe_count + 1'b1;
            end
            sbe_sticky <= 1'b1;
            err_addr   <= rd_addr_reg;
        end
    end

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Directed bench for ecc_mem_ctrl with a behavioural 1-cycle read-first SRAM.
module tb_ecc_mem_ctrl;
    import ecc_mem_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int CNTW = 4;
    localparam int CW = code_width(DW);

    logic            clk = 1'b0;
    logic            hw_rst;
    logic            wr_en, rd_en, inj_sbe, inj_dbe, err_clr;
    logic [AW:0]     wr_addr, rd_addr;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   data_out;
    logic            rd_valid, sbe_flag, dbe_flag, sbe_sticky, dbe_sticky, scrub_busy;
    logic [CNTW-1:0] sbe_count, dbe_count;
    logic [AW-1:0]   err_addr, mem_waddr, mem_raddr;
    logic            mem_we, mem_re;
    logic [CW-1:0]   mem_wdata, mem_rdata;
    logic [CW-1:0]   sram [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ecc_mem_ctrl #(
        .DATA_WIDTH(DW),
        .MEM_CTRL_ADDR_WIDTH(AW),
        .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .hw_rst(hw_rst),
        .ECC_ctrl_wr_en(wr_en), .ECC_ctrl_wr_addr_bus(wr_addr),
        .ECC_ctrl_write_data_bus(wr_data),
        .ECC_ctrl_rd_en(rd_en), .ECC_ctrl_rd_addr_bus(rd_addr),
        .ECC_ctrl_data_out(data_out), .ECC_ctrl_rd_valid(rd_valid),
        .inj_sbe(inj_sbe), .inj_dbe(inj_dbe), .err_clr(err_clr),
        .sbe_flag(sbe_flag), .dbe_flag(dbe_flag),
        .sbe_sticky(sbe_sticky), .dbe_sticky(dbe_sticky),
        .sbe_count(sbe_count), .dbe_count(dbe_count),
        .err_addr(err_addr), .scrub_busy(scrub_busy),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= sram[mem_raddr];
        if (mem_we) sram[mem_waddr] <= mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; inj_sbe = 0; inj_dbe = 0; err_clr = 0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic sb, input logic db);
        wr_en = 1; wr_addr = a[AW:0]; wr_data = d; inj_sbe = sb; inj_dbe = db;
    endtask

    task automatic rd(input int a);
        rd_en = 1; rd_addr = a[AW:0];
    endtask

    initial begin
        idle();
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        hw_rst = 1;
        wr_en = 1; rd_en = 1;
        #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        step(); step();
        hw_rst = 0; idle();
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_scrub_busy", scrub_busy, 0);
        chk("rst_sbe_count", sbe_count, 0);
        chk("rst_dbe_count", dbe_count, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_stickies", {sbe_sticky, dbe_sticky}, 0);

        // Encoder layout: data bit0 -> index 3, bit1 -> index 5
        wr(200, 32'h1, 0, 0); #1; chk("enc_d1", mem_wdata, 39'hF);
        wr(200, 32'h2, 0, 0); #1; chk("enc_d2", mem_wdata, 39'h33);
        wr(200, 32'h0, 1, 0); #1; chk("enc_inj_sbe", mem_wdata, 39'h8);
        wr(200, 32'h0, 0, 1); #1; chk("enc_inj_dbe", mem_wdata, 39'h28);

        // Clean write/read, wrap bit ignored
        wr(32'h405, 32'hDEADBEEF, 0, 0); #1;
        chk("t1_mem_we", mem_we, 1);
        chk("t1_mem_waddr", mem_waddr, 5);
        step(); idle(); rd(5); #1;
        chk("t1_mem_re", mem_re, 1);
        chk("t1_mem_raddr", mem_raddr, 5);
        step(); idle();
        chk("t1_valid", rd_valid, 1);
        chk("t1_data", data_out, 32'hDEADBEEF);
        chk("t1_flags", {sbe_flag, dbe_flag}, 0);
        step();
        chk("t1_valid_drop", rd_valid, 0);
        chk("t1_counts", {sbe_count, dbe_count}, 0);
        chk("t1_busy", scrub_busy, 0);

        // Single-bit error: corrected, counted, scrubbed at N+2
        wr(3, 32'h12345678, 1, 0); step(); idle();
        rd(3); step(); idle();
        chk("t2_data", data_out, 32'h12345678);
        chk("t2_sbe_flag", sbe_flag, 1);
        chk("t2_dbe_flag", dbe_flag, 0);
        chk("t2_mem_we_n1", mem_we, 0);
        step();
        chk("t2_sbe_count", sbe_count, 1);
        chk("t2_sbe_sticky", sbe_sticky, 1);
        chk("t2_err_addr", err_addr, 3);
        chk("t2_busy", scrub_busy, 1);
        chk("t2_scrub_we", mem_we, 1);
        chk("t2_scrub_addr", mem_waddr, 3);
        step();
        chk("t2_busy_drop", scrub_busy, 0);
        chk("t2_mem_we_idle", mem_we, 0);
        rd(3); step(); idle();
        chk("t2_reread_flag", sbe_flag, 0);
        chk("t2_reread_data", data_out, 32'h12345678);
        step();
        chk("t2_count_hold", sbe_count, 1);

        // Double-bit error: raw data (bits 0,1 flipped), no scrub
        wr(7, 32'h0000FFFF, 0, 1); step(); idle();
        rd(7); step(); idle();
        chk("t3_dbe_flag", dbe_flag, 1);
        chk("t3_sbe_flag", sbe_flag, 0);
        chk("t3_raw_data", data_out, 32'h0000FFFC);
        step();
        chk("t3_dbe_count", dbe_count, 1);
        chk("t3_dbe_sticky", dbe_sticky, 1);
        chk("t3_err_addr", err_addr, 7);
        chk("t3_busy", scrub_busy, 0);
        chk("t3_mem_we", mem_we, 0);

        // Scrub cancelled by a functional write to the pending address
        wr(9, 32'hA5A5A5A5, 1, 0); step(); idle();
        rd(9); step(); idle();
        wr(20, 32'h0, 0, 0); #1;
        chk("t4_sbe_flag", sbe_flag, 1);
        step(); wr(21, 32'h0, 0, 0); #1;
        chk("t4_busy_a", scrub_busy, 1);
        chk("t4_waddr_func", mem_waddr, 21);
        step(); wr(9, 32'h11111111, 0, 0); #1;
        chk("t4_busy_b", scrub_busy, 1);
        step(); idle(); #1;
        chk("t4_busy_drop", scrub_busy, 0);
        chk("t4_no_scrub", mem_we, 0);
        rd(9); step(); idle();
        chk("t4_data", data_out, 32'h11111111);
        chk("t4_flag", sbe_flag, 0);
        step();

        // 20 SBE reads while scrub is held off: counter saturates at 15
        wr(30, 32'hCAFEF00D, 1, 0); step(); idle();
        for (int i = 0; i < 20; i++) begin
            rd(30); wr(100, i, 0, 0);
            step();
        end
        idle(); #1;
        chk("t5_last_flag", sbe_flag, 1);
        chk("t5_scrub_we", mem_we, 1);
        chk("t5_scrub_addr", mem_waddr, 30);
        step();
        chk("t5_sbe_sat", sbe_count, 15);
        chk("t5_dbe_hold", dbe_count, 1);
        chk("t5_err_addr", err_addr, 30);
        rd(30); step(); idle();
        chk("t5_scrubbed", {sbe_flag, dbe_flag}, 0);
        chk("t5_scrub_data", data_out, 32'hCAFEF00D);
        step();

        // err_clr wins over a same-cycle increment
        wr(40, 32'h0F0F0F0F, 1, 0); step(); idle();
        rd(40); step(); idle();
        err_clr = 1; #1;
        chk("t6_sbe_flag", sbe_flag, 1);
        step(); err_clr = 0; #1;
        chk("t6_sbe_count", sbe_count, 0);
        chk("t6_dbe_count", dbe_count, 0);
        chk("t6_stickies", {sbe_sticky, dbe_sticky}, 0);
        chk("t6_err_addr", err_addr, 0);
        step(); step();

        // Reset during a read while a scrub is pending
        wr(50, 32'h55AA55AA, 1, 0); step(); idle();
        rd(50); step(); idle();
        wr(60, 32'h0, 0, 0); step();
        wr(61, 32'h0, 0, 0); rd(5); #1;
        chk("t7_busy_pre", scrub_busy, 1);
        chk("t7_count_pre", sbe_count, 1);
        hw_rst = 1; #1;
        chk("t7_rst_mem_we", mem_we, 0);
        chk("t7_rst_mem_re", mem_re, 0);
        chk("t7_rst_busy", scrub_busy, 0);
        step();
        hw_rst = 0; idle(); #1;
        chk("t7_rd_valid", rd_valid, 0);
        chk("t7_no_scrub", mem_we, 0);
        chk("t7_sbe_count", sbe_count, 0);
        chk("t7_sticky", sbe_sticky, 0);
        chk("t7_err_addr", err_addr, 0);
        step();
        chk("t7_rd_valid_b", rd_valid, 0);
        chk("t7_no_scrub_b", mem_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
